pc_redirect_controller: RTL and testbench
=========================================

Name: pc_redirect_controller

Overview:
Control block for the program counter stage. It drives the three next-PC mux selects (execute/RS1 leg, predicted leg, mispredict override) and the decode/execute clear signals. It holds a 2-bit saturating branch history table (BHT) for taken/not-taken prediction at fetch, and resolves predictions against execute-stage outcomes. It sits beside the PC stage and is fed by fetch (PC, BTB hit) and execute (ALU op, branch outcome).

Parameters:
ALU_JAL, 5'b01010, ALU op code for JAL
ALU_JALR, 5'b01011, ALU op code for JALR
BHT_INDEX_BITS, 6, log2 of BHT entries; index = PC[BHT_INDEX_BITS+1:2]

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
STALL_EXECUTION_STAGE  in  1  execute stage frozen this cycle
ALU_INSTRUCTION  in  5  ALU op of the instruction in execute
BRANCH_EXECUTION  in  1  instruction in execute is a conditional branch
BRANCH_TAKEN  in  1  conditional branch outcome in execute
PREDICTED_TAKEN_EXECUTION  in  1  prediction carried down with the execute instruction
PC_EXECUTION  in  32  PC of the execute instruction (BHT update index)
PC_FETCH  in  32  current fetch PC (BHT lookup index)
BTB_HIT  in  1  predictor holds a target for PC_FETCH
BTB_IS_JUMP  in  1  BTB entry is an unconditional JAL
PC_RS_1_SELECT  out  1  0 = execute-corrected PC leg, 1 = RS1 leg
PC_PREDICT_SELECT  out  1  0 = PC+4, 1 = predicted target
PC_MISPREDICT_SELECT  out  1  1 = override with the execute/RS1 leg
PREDICT_TAKEN  out  1  prediction for PC_FETCH, pipelined with the instruction
CLEAR_DECODING_STAGE  out  1  squash decode register
CLEAR_EXECUTION_STAGE  out  1  squash execute register
MISPREDICT_COUNT  out  32  redirect performance counter

Behaviour:
- Reset (async, RST_N=0) sets:
  - state=RUN
  - CLEAR_* = 0
  - MISPREDICT_COUNT = 0
  - every BHT entry = 2'b01 (weakly not taken)
- Outputs during reset:
  - CLEAR_* drop immediately on RST_N falling, with no clock edge needed.
  - Combinational selects follow the RUN rules.
- Lookup (combinational):
  - ctr = BHT[PC_FETCH index]
  - PC_PREDICT_SELECT = PREDICT_TAKEN = BTB_HIT & (BTB_IS_JUMP | ctr[1])
  - Forced to 0 whenever PC_MISPREDICT_SELECT = 1.
- An execute instruction is evaluated only when: state=RUN, STALL_EXECUTION_STAGE=0, RST_N=1.
- Redirect conditions for an evaluated instruction:
  - ALU_JALR: always redirect, PC_RS_1_SELECT=1.
  - ALU_JAL: redirect iff PREDICTED_TAKEN_EXECUTION=0, PC_RS_1_SELECT=0.
  - BRANCH_EXECUTION: redirect iff BRANCH_TAKEN != PREDICTED_TAKEN_EXECUTION, PC_RS_1_SELECT=0. The datapath presents the corrected address (target or PC+4) on the execute leg.
  - Otherwise PC_RS_1_SELECT=0.
- Redirect timing:
  - In the redirect cycle, PC_MISPREDICT_SELECT=1 combinationally (zero latency; the PC loads the corrected address on that edge).
  - At that edge: state goes to FLUSH, CLEAR_DECODING_STAGE and CLEAR_EXECUTION_STAGE go to 1 (registered), and MISPREDICT_COUNT increments.
- MISPREDICT_COUNT saturates at 32'hFFFFFFFF; it never wraps.
- FLUSH state:
  - CLEAR_* held at 1; no redirect evaluated; selects all 0.
  - Next edge: if STALL_EXECUTION_STAGE=0, go to RUN and CLEAR_* go to 0. If stalled, stay in FLUSH (clear wins over stall).
  - Each flush therefore lasts at least one full cycle.
- BHT update:
  - On any evaluated BRANCH_EXECUTION, at the clock edge, BHT[PC_EXECUTION index] is saturating-incremented if taken, decremented if not.
  - Saturation: 11 stays 11, 00 stays 00.
  - No update for JAL/JALR, in FLUSH, or when stalled.
- Same-index lookup and update in one cycle: lookup returns the pre-update value (read-before-write).
- ALU_JAL/JALR take priority over BRANCH_EXECUTION if both are asserted (malformed input).

Test Plan:
1. Post-reset, PC_FETCH=0x100, BTB_HIT=1, BTB_IS_JUMP=0 -> PC_PREDICT_SELECT=0, PREDICT_TAKEN=0. With BTB_IS_JUMP=1 -> both 1.
2. Branch at PC_EXECUTION=0x100, BRANCH_TAKEN=1, PREDICTED_TAKEN_EXECUTION=0, repeated across RUN cycles:
   - -> PC_MISPREDICT_SELECT=1, PC_RS_1_SELECT=0 each time.
   - -> CLEAR_* high exactly one cycle after each.
   - -> MISPREDICT_COUNT=2.
   - -> lookup of 0x100 with BTB_HIT=1 gives PC_PREDICT_SELECT=1 (ctr 01->10->11).
3. JALR in execute, no stall -> PC_RS_1_SELECT=1, PC_MISPREDICT_SELECT=1 same cycle, PC_PREDICT_SELECT=0. JAL with PREDICTED_TAKEN_EXECUTION=1 -> no redirect, count unchanged.
4. Mispredicted branch held with STALL_EXECUTION_STAGE=1 for 3 cycles -> selects, clears, count and BHT unchanged. Stall drops -> redirect in that cycle, count+1.
5. JALR presented during FLUSH -> ignored (PC_MISPREDICT_SELECT=0). Stall raised during FLUSH for 2 cycles -> CLEAR_* stay 1 for 3 cycles total, then 0.
6. RST_N pulled low mid-FLUSH between clock edges -> CLEAR_*=0 immediately, count=0. Next lookup of previously trained index -> PREDICT_TAKEN=0 (ctr back to 01).

Source files
------------

// File: rtl/pc_redirect_controller.sv
// Next-PC select and pipeline squash control with a 2-bit saturating branch history table.
// Redirects resolve combinationally in execute; the squash that follows is registered.
module pc_redirect_controller #(
    parameter logic [4:0] ALU_JAL        = 5'b01010,
    parameter logic [4:0] ALU_JALR       = 5'b01011,
    parameter int         BHT_INDEX_BITS = 6
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall_execution_stage,
    input  logic [4:0]  i_alu_instruction,
    input  logic        i_branch_execution,
    input  logic        i_branch_taken,
    input  logic        i_predicted_taken_execution,
    input  logic [31:0] i_pc_execution,
    input  logic [31:0] i_pc_fetch,
    input  logic        i_btb_hit,
    input  logic        i_btb_is_jump,
    output logic        o_pc_rs_1_select,
    output logic        o_pc_predict_select,
    output logic        o_pc_mispredict_select,
    output logic        o_predict_taken,
    output logic        o_clear_decoding_stage,
    output logic        o_clear_execution_stage,
    output logic [31:0] o_mispredict_count
);

    // state | meaning
    // RUN   | execute instruction resolved each unstalled cycle
    // FLUSH | decode/execute squashed, nothing resolved
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam int BHT_ENTRIES = 1 << BHT_INDEX_BITS;

    state_t      r_state;
    logic        r_clear;
    logic [31:0] r_mispredict_count;
    logic [1:0]  r_bht [BHT_ENTRIES];

    logic [BHT_INDEX_BITS-1:0] w_fetch_idx;
    logic [BHT_INDEX_BITS-1:0] w_exec_idx;
    logic [1:0]                w_fetch_ctr;
    logic                      w_eval;
    logic                      w_is_jal;
    logic                      w_is_jalr;
    logic                      w_redirect;
    logic                      w_bht_update;

    assign w_fetch_idx = i_pc_fetch[BHT_INDEX_BITS+1:2];
    assign w_exec_idx  = i_pc_execution[BHT_INDEX_BITS+1:2];
    assign w_fetch_ctr = r_bht[w_fetch_idx];
    assign w_is_jal    = (i_alu_instruction == ALU_JAL);
    assign w_is_jalr   = (i_alu_instruction == ALU_JALR);

    // Reset low also blocks evaluation so nothing redirects while the block is held.
    assign w_eval = (r_state == RUN) & ~i_stall_execution_stage & i_rst_n;

    always_comb begin
        w_redirect = 1'b0;
        if (w_eval) begin
            if (w_is_jalr) begin
                w_redirect = 1'b1;
            end else if (w_is_jal) begin
                w_redirect = ~i_predicted_taken_execution;
            end else if (i_branch_execution) begin
                w_redirect = i_branch_taken ^ i_predicted_taken_execution;
            end
        end
    end

    assign w_bht_update = w_eval & i_branch_execution & ~w_is_jal & ~w_is_jalr;

    assign o_pc_rs_1_select        = w_eval & w_is_jalr;
    assign o_pc_mispredict_select  = w_redirect;
    assign o_predict_taken         = (r_state == RUN) & ~w_redirect & i_btb_hit
                                     & (i_btb_is_jump | w_fetch_ctr[1]);
    assign o_pc_predict_select     = o_predict_taken;
    assign o_clear_decoding_stage  = r_clear;
    assign o_clear_execution_stage = r_clear;
    assign o_mispredict_count      = r_mispredict_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state            <= RUN;
            r_clear            <= 1'b0;
            r_mispredict_count <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_redirect) begin
                        r_state <= FLUSH;
                        r_clear <= 1'b1;
                        if (r_mispredict_count != 32'hFFFF_FFFF) begin
                            r_mispredict_count <= r_mispredict_count + 32'd1;
                        end
                    end
                end
                FLUSH: begin
                    // Clear outranks stall: the squash holds until execute is free to move.
                    if (!i_stall_execution_stage) begin
                        r_state <= RUN;
                        r_clear <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_clear <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_bht_update) begin
            if (i_branch_taken) begin
                if (r_bht[w_exec_idx] != 2'b11) begin
                    r_bht[w_exec_idx] <= r_bht[w_exec_idx] + 2'd1;
                end
            end else if (r_bht[w_exec_idx] != 2'b00) begin
                r_bht[w_exec_idx] <= r_bht[w_exec_idx] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Directed walk through the redirect/flush/BHT scenarios, then randomized traffic
// checked every cycle against a behavioural model of the controller.
module tb_pc_redirect_controller;

    localparam logic [4:0] JAL  = 5'b01010;
    localparam logic [4:0] JALR = 5'b01011;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [4:0]  alu;
    logic        br;
    logic        tk;
    logic        pte;
    logic [31:0] pc_ex;
    logic [31:0] pc_f;
    logic        hit;
    logic        jmp;
    logic        rs1_sel;
    logic        pred_sel;
    logic        misp_sel;
    logic        ptk;
    logic        clr_d;
    logic        clr_e;
    logic [31:0] cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: flush flag, counter, and BHT counters as plain integers 0..3.
    bit      m_flush;
    longint  m_count;
    int      m_bht [64];

    pc_redirect_controller dut (
        .i_clk                       (clk),
        .i_rst_n                     (rst_n),
        .i_stall_execution_stage     (stall),
        .i_alu_instruction           (alu),
        .i_branch_execution          (br),
        .i_branch_taken              (tk),
        .i_predicted_taken_execution (pte),
        .i_pc_execution              (pc_ex),
        .i_pc_fetch                  (pc_f),
        .i_btb_hit                   (hit),
        .i_btb_is_jump               (jmp),
        .o_pc_rs_1_select            (rs1_sel),
        .o_pc_predict_select         (pred_sel),
        .o_pc_mispredict_select      (misp_sel),
        .o_predict_taken             (ptk),
        .o_clear_decoding_stage      (clr_d),
        .o_clear_execution_stage     (clr_e),
        .o_mispredict_count          (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_flush = 1'b0;
        m_count = 0;
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
    endfunction

    function automatic bit m_eval();
        return !m_flush && !stall && rst_n;
    endfunction

    function automatic bit m_redirect();
        if (!m_eval()) return 1'b0;
        if (alu == JALR) return 1'b1;
        if (alu == JAL) return !pte;
        if (br) return tk != pte;
        return 1'b0;
    endfunction

    function automatic bit m_predict();
        return !m_flush && !m_redirect() && hit && (jmp || m_bht[pc_f[7:2]] >= 2);
    endfunction

    task automatic check_all();
        compare("rs1_sel", {31'd0, rs1_sel}, {31'd0, m_eval() && alu == JALR});
        compare("mispredict_sel", {31'd0, misp_sel}, {31'd0, m_redirect()});
        compare("predict_sel", {31'd0, pred_sel}, {31'd0, m_predict()});
        compare("predict_taken", {31'd0, ptk}, {31'd0, m_predict()});
        compare("clear_decode", {31'd0, clr_d}, {31'd0, m_flush});
        compare("clear_execute", {31'd0, clr_e}, {31'd0, m_flush});
        compare("mispredict_count", cnt, m_count[31:0]);
    endtask

    function automatic void m_clock();
        bit redir;
        bit upd;
        int idx;
        redir = m_redirect();
        upd   = m_eval() && br && alu != JAL && alu != JALR;
        idx   = int'(pc_ex[7:2]);
        if (upd) begin
            if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        end
        if (m_flush) begin
            if (!stall) m_flush = 1'b0;
        end else if (redir) begin
            m_flush = 1'b1;
            if (m_count != 64'hFFFF_FFFF) m_count++;
        end
    endfunction

    // One clock: inputs already applied; compare at negedge, advance model at posedge.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; alu = 5'd0; br = 1'b0; tk = 1'b0; pte = 1'b0;
        pc_ex = 32'h0; pc_f = 32'h0; hit = 1'b0; jmp = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        m_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Post-reset lookup: weakly-not-taken unless BTB says jump.
        pc_f = 32'h100; hit = 1'b1; jmp = 1'b0;
        #1;
        compare("t1_predict_sel_nt", {31'd0, pred_sel}, 32'd0);
        compare("t1_predict_taken_nt", {31'd0, ptk}, 32'd0);
        compare("t1_reset_clear", {31'd0, clr_d}, 32'd0);
        compare("t1_reset_count", cnt, 32'd0);
        jmp = 1'b1;
        #1;
        compare("t1_predict_sel_jump", {31'd0, pred_sel}, 32'd1);
        compare("t1_predict_taken_jump", {31'd0, ptk}, 32'd1);
        step();

        // Two mispredicted taken branches at 0x100 train the counter to strongly taken.
        hit = 1'b0; jmp = 1'b0;
        br = 1'b1; tk = 1'b1; pte = 1'b0; pc_ex = 32'h100;
        for (int k = 0; k < 2; k++) begin
            #1;
            compare("t2_redirect", {31'd0, misp_sel}, 32'd1);
            compare("t2_rs1_sel", {31'd0, rs1_sel}, 32'd0);
            step();
            compare("t2_clear_high", {31'd0, clr_d & clr_e}, 32'd1);
            step();
            compare("t2_clear_low", {31'd0, clr_d | clr_e}, 32'd0);
        end
        compare("t2_count", cnt, 32'd2);
        br = 1'b0; pc_f = 32'h100; hit = 1'b1;
        #1;
        compare("t2_trained_predict", {31'd0, pred_sel}, 32'd1);

        // JALR always redirects through RS1 and masks prediction.
        alu = JALR; jmp = 1'b1;
        #1;
        compare("t3_jalr_rs1", {31'd0, rs1_sel}, 32'd1);
        compare("t3_jalr_redirect", {31'd0, misp_sel}, 32'd1);
        compare("t3_jalr_predict_masked", {31'd0, pred_sel}, 32'd0);
        step();
        alu = JAL; pte = 1'b1;
        step();
        #1;
        compare("t3_jal_no_redirect", {31'd0, misp_sel}, 32'd0);
        step();
        compare("t3_count", cnt, 32'd3);

        // Stalled mispredict is inert until the stall drops.
        alu = 5'd0; hit = 1'b0; jmp = 1'b0;
        br = 1'b1; tk = 1'b0; pte = 1'b1; pc_ex = 32'h100; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            compare("t4_stalled_no_redirect", {31'd0, misp_sel}, 32'd0);
            step();
            compare("t4_stalled_no_clear", {31'd0, clr_d}, 32'd0);
            compare("t4_stalled_count", cnt, 32'd3);
        end
        stall = 1'b0;
        #1;
        compare("t4_unstall_redirect", {31'd0, misp_sel}, 32'd1);
        step();
        compare("t4_count", cnt, 32'd4);

        // In FLUSH: JALR ignored, stall stretches the clear.
        br = 1'b0; alu = JALR; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) stall = 1'b0;
            #1;
            compare("t5_flush_ignores_jalr", {31'd0, misp_sel}, 32'd0);
            compare("t5_flush_clear", {31'd0, clr_e}, 32'd1);
            step();
        end
        alu = 5'd0;
        #1;
        compare("t5_clear_released", {31'd0, clr_d}, 32'd0);

        // Async reset mid-FLUSH restores everything without a clock edge.
        alu = JALR;
        step();
        alu = 5'd0;
        compare("t6_in_flush", {31'd0, clr_d}, 32'd1);
        rst_n = 1'b0;
        #1;
        m_reset();
        compare("t6_async_clear", {31'd0, clr_d | clr_e}, 32'd0);
        compare("t6_async_count", cnt, 32'd0);
        #1;
        rst_n = 1'b1;
        pc_f = 32'h100; hit = 1'b1; jmp = 1'b0;
        #1;
        compare("t6_bht_reset", {31'd0, ptk}, 32'd0);
        step();

        // Randomized traffic with aliasing PCs and occasional async resets.
        for (int c = 0; c < 3000; c++) begin
            int r;
            r     = int'($urandom_range(0, 9));
            alu   = (r == 0) ? JAL : (r == 1) ? JALR : 5'($urandom);
            br    = 1'($urandom);
            tk    = 1'($urandom);
            pte   = 1'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            pc_ex = $urandom & 32'hFFFF_F01C;
            pc_f  = ($urandom_range(0, 1) == 0) ? pc_ex : ($urandom & 32'hFFFF_F01C);
            hit   = 1'($urandom);
            jmp   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #1;
                m_reset();
                compare("rand_async_clear", {31'd0, clr_d}, 32'd0);
                compare("rand_async_count", cnt, 32'd0);
                #1;
                rst_n = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
